// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive/transmit framing logic.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam logic [3:0]  STOP_IDX   = 4'd9;

    // Bit index after a data sample: jumps to the stop slot once the last data bit is in.
    function automatic logic [3:0] next_data_idx(input logic [3:0] idx, input int unsigned data_bits);
        logic [3:0] nxt;
        if (idx == 4'(data_bits)) begin
            nxt = STOP_IDX;
        end else begin
            nxt = idx + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/serial_rx_frame_if.sv
// Line-side inputs and character-side outputs of the receive framer.
interface serial_rx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    import serial_pkg::*;

    logic                        enable;
    logic                        rx_in;
    logic [DATA_BITS-1:0]        char_out;
    logic                        char_valid;
    logic                        frame_err;
    logic                        busy;
    logic [$bits(STOP_IDX)-1:0]  bit_idx;

    modport master (
        output enable,
        output rx_in,
        input  char_out,
        input  char_valid,
        input  frame_err,
        input  busy,
        input  bit_idx
    );

    modport slave (
        input  enable,
        input  rx_in,
        output char_out,
        output char_valid,
        output frame_err,
        output busy,
        output bit_idx
    );

endinterface

// File: rtl/rx_sample_ctr.sv
// Oversample position counter within one bit period, with mid-bit and last-sample flags.
module rx_sample_ctr #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clr,
    output logic at_mid,
    output logic at_last
);

    localparam int unsigned SW   = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

    logic [SW-1:0] scnt_q;
    logic [SW-1:0] scnt_d;

    // Next count: wraps at the last sample, clears on request, frozen without a tick.
    always_comb begin
        scnt_d = scnt_q;
        if (tick) begin
            if (clr || at_last) begin
                scnt_d = {SW{1'b0}};
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= {SW{1'b0}};
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign at_mid  = (scnt_q == MID);
    assign at_last = (scnt_q == LAST);

endmodule

// File: rtl/serial_rx_frame.sv
// Receive framer: qualifies start bits mid-bit, shifts data LSB-first, checks the stop bit
// and emits one registered valid or framing-error pulse per frame.
module serial_rx_frame
    import serial_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_rx_frame_if.slave bus
);

    rx_state_t            state_q,      state_d;
    logic [3:0]           bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] char_out_q,   char_out_d;
    logic                 char_valid_q, char_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 busy_q,       busy_d;

    logic ctr_clr_s;
    logic at_mid_s;
    logic at_last_s;

    rx_sample_ctr #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sample_ctr (
        .clk     (clk),
        .rst     (rst),
        .tick    (bus.enable),
        .clr     (ctr_clr_s),
        .at_mid  (at_mid_s),
        .at_last (at_last_s)
    );

    // Next-state, datapath and pulse computation; nothing but the pulses moves without a tick.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        ctr_clr_s    = 1'b0;

        if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    // The detecting tick is sample 0, so the counter is allowed to step to 1.
                    if (!bus.rx_in) begin
                        state_d = START;
                    end else begin
                        ctr_clr_s = 1'b1;
                    end
                end
                START: begin
                    if (at_mid_s) begin
                        ctr_clr_s = 1'b1;
                        if (!bus.rx_in) begin
                            state_d   = DATA;
                            bit_idx_d = 4'd1;
                        end else begin
                            state_d   = IDLE;
                            bit_idx_d = 4'd0;
                        end
                    end else begin
                        ctr_clr_s = 1'b0;
                    end
                end
                DATA: begin
                    if (at_last_s) begin
                        shift_d   = {bus.rx_in, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = next_data_idx(bit_idx_q, DATA_BITS);
                        if (bit_idx_q == 4'(DATA_BITS)) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        ctr_clr_s = 1'b0;
                    end
                end
                STOP: begin
                    if (at_last_s) begin
                        if (bus.rx_in) begin
                            char_out_d   = shift_q;
                            char_valid_d = 1'b1;
                            state_d      = IDLE;
                            bit_idx_d    = 4'd0;
                        end else begin
                            frame_err_d  = 1'b1;
                            state_d      = RECOVER;
                        end
                    end else begin
                        ctr_clr_s = 1'b0;
                    end
                end
                RECOVER: begin
                    // A held-low line stays here so a break never looks like a new start.
                    ctr_clr_s = 1'b1;
                    if (bus.rx_in) begin
                        state_d   = IDLE;
                        bit_idx_d = 4'd0;
                    end else begin
                        state_d   = RECOVER;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_idx_d = 4'd0;
                    ctr_clr_s = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= 4'd0;
            shift_q      <= {DATA_BITS{1'b0}};
            char_out_q   <= {DATA_BITS{1'b0}};
            char_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.char_out   = char_out_q;
    assign bus.char_valid = char_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
    assign bus.bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench for serial_rx_frame: a table of whole frames plus hand-written corner sequences.
module tb_serial_rx_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_rx_frame_if #(.DATA_BITS(8)) bus ();

    serial_rx_frame #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_char;
    } frame_vec_t;

    frame_vec_t tv [6];

    int n_pass  = 0;
    int n_total = 0;
    int tick_no = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int vt [$];
    logic [7:0] vc [$];
    bit track = 1'b0;
    int base  = 0;
    int trk_err = 0;

    function automatic logic [3:0] exp_idx(input int k);
        logic [3:0] r;
        if (k < 7)         r = 4'd0;
        else if (k < 135)  r = 4'(1 + (k - 7) / 16);
        else if (k < 151)  r = 4'd9;
        else               r = 4'd0;
        return r;
    endfunction

    function automatic logic exp_busy(input int k);
        return (k >= 0) && (k < 151);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic rx);
        int k;
        @(negedge clk);
        bus.enable = en;
        bus.rx_in  = rx;
        @(posedge clk);
        #1;
        if (en) tick_no++;
        if (bus.char_valid === 1'b1) begin
            valid_cnt++;
            vt.push_back(tick_no);
            vc.push_back(bus.char_out);
        end
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.char_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
        if (track) begin
            k = tick_no - base - 1;
            if (bus.bit_idx !== exp_idx(k) || bus.busy !== exp_busy(k)) trk_err++;
        end
    endtask

    task automatic send_bits(input logic b, input int n);
        repeat (n) cyc(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bits(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits(d[i], 16);
        send_bits(stop_bit, 16);
    endtask

    // One oversample tick followed by three cycles with enable low.
    task automatic send_slow(input logic b, input int n);
        repeat (n) begin
            cyc(1'b1, b);
            repeat (3) cyc(1'b0, b);
        end
    endtask

    task automatic clr_mon();
        valid_cnt = 0;
        err_cnt   = 0;
        vt.delete();
        vc.delete();
    endtask

    initial begin
        logic [7:0] d;
        tv[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_valid: 1, exp_err: 0, exp_char: 8'hA5};
        tv[1] = '{data: 8'h3C, stop_bit: 1'b0, exp_valid: 0, exp_err: 1, exp_char: 8'hA5};
        tv[2] = '{data: 8'h00, stop_bit: 1'b1, exp_valid: 1, exp_err: 0, exp_char: 8'h00};
        tv[3] = '{data: 8'hFF, stop_bit: 1'b1, exp_valid: 1, exp_err: 0, exp_char: 8'hFF};
        tv[4] = '{data: 8'h81, stop_bit: 1'b0, exp_valid: 0, exp_err: 1, exp_char: 8'hFF};
        tv[5] = '{data: 8'h7E, stop_bit: 1'b1, exp_valid: 1, exp_err: 0, exp_char: 8'h7E};

        // Reset state
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b1);
        check("rst_char_out",   int'(bus.char_out),   0);
        check("rst_char_valid", int'(bus.char_valid), 0);
        check("rst_frame_err",  int'(bus.frame_err),  0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_bit_idx",    int'(bus.bit_idx),    0);
        rst = 1'b0;
        send_bits(1'b1, 5);

        // Table of whole frames, each followed by an idle gap
        for (int i = 0; i < 6; i++) begin
            clr_mon();
            send_frame(tv[i].data, tv[i].stop_bit);
            send_bits(1'b1, 20);
            check($sformatf("vec%0d_valid", i), valid_cnt, tv[i].exp_valid);
            check($sformatf("vec%0d_err", i),   err_cnt,   tv[i].exp_err);
            check($sformatf("vec%0d_char", i),  int'(bus.char_out), int'(tv[i].exp_char));
        end

        // 0xA5 with exact stop-sample timing and bit_idx/busy tracking
        clr_mon();
        base = tick_no; trk_err = 0; track = 1'b1;
        send_frame(8'hA5, 1'b1);
        send_bits(1'b1, 10);
        track = 1'b0;
        check("a5_valid_cnt", valid_cnt, 1);
        check("a5_err_cnt",   err_cnt,   0);
        check("a5_char",      (vc.size() > 0) ? int'(vc[0]) : -1, 8'hA5);
        check("a5_valid_tick", (vt.size() > 0) ? vt[0] - base - 1 : -1, 151);
        check("a5_track",     trk_err,   0);

        // False start: 4 low ticks then high
        clr_mon();
        send_bits(1'b0, 4);
        check("fs_busy_rise", int'(bus.busy), 1);
        send_bits(1'b1, 4);
        check("fs_busy_t7",   int'(bus.busy), 0);
        check("fs_bit_idx",   int'(bus.bit_idx), 0);
        send_bits(1'b1, 10);
        check("fs_pulses",    valid_cnt + err_cnt, 0);
        check("fs_char",      int'(bus.char_out), 8'hA5);

        // Bad stop bit followed by a 40-tick break
        clr_mon();
        send_frame(8'h3C, 1'b0);
        send_bits(1'b0, 40);
        check("brk_err_cnt",  err_cnt,   1);
        check("brk_valid",    valid_cnt, 0);
        check("brk_char",     int'(bus.char_out), 8'hA5);
        check("brk_busy_low", int'(bus.busy), 1);
        cyc(1'b1, 1'b1);
        check("brk_busy_exit", int'(bus.busy), 0);
        send_bits(1'b1, 30);
        check("brk_no_new",   valid_cnt + err_cnt, 1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        clr_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bits(1'b1, 20);
        check("b2b_valid_cnt", valid_cnt, 2);
        check("b2b_char0",  (vc.size() > 0) ? int'(vc[0]) : -1, 8'h00);
        check("b2b_char1",  (vc.size() > 1) ? int'(vc[1]) : -1, 8'hFF);
        check("b2b_spacing", (vt.size() > 1) ? vt[1] - vt[0] : -1, 160);

        // 0x5A with enable one cycle in four
        clr_mon();
        base = tick_no; trk_err = 0; track = 1'b1;
        d = 8'h5A;
        send_slow(1'b0, 16);
        for (int i = 0; i < 8; i++) send_slow(d[i], 16);
        send_slow(1'b1, 16);
        send_slow(1'b1, 4);
        track = 1'b0;
        check("slow_valid_cnt", valid_cnt, 1);
        check("slow_char",   (vc.size() > 0) ? int'(vc[0]) : -1, 8'h5A);
        check("slow_tick",   (vt.size() > 0) ? vt[0] - base - 1 : -1, 151);
        check("slow_track",  trk_err, 0);
        check("slow_err",    err_cnt, 0);

        // Reset during data bit 4 of 0xC3, then a clean 0x81
        clr_mon();
        d = 8'hC3;
        send_bits(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bits(d[i], 16);
        send_bits(d[4], 8);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        check("mrst_busy",    int'(bus.busy),     0);
        check("mrst_bit_idx", int'(bus.bit_idx),  0);
        check("mrst_char",    int'(bus.char_out), 0);
        send_bits(1'b1, 5);
        check("mrst_pulses",  valid_cnt + err_cnt, 0);
        send_frame(8'h81, 1'b1);
        send_bits(1'b1, 10);
        check("mrst_next_cnt",  valid_cnt, 1);
        check("mrst_next_char", int'(bus.char_out), 8'h81);

        check("no_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_rx_frame.md
# serial_rx_frame

Receive-side framing stage of the serial network. Watches the idle-high serial line and qualifies start bits by mid-bit sampling. Shifts in 8 data bits LSB-first, checks the stop bit, and emits one byte per frame with a valid pulse or a framing-error pulse. It sits between the line synchronizer and the character consumer, and exposes its 0–9 bit index (start=0, data=1–8, stop=9) for the bit-index/debug logic.

## Interface
- OVERSAMPLE, 16: enable ticks per bit; must be even and ≥4.
- DATA_BITS, 8: data bits per frame; the frame is 1 start + DATA_BITS + 1 stop.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  oversample tick; the block advances only on cycles with enable=1.
- rx_in  in  1  synchronized serial line; idle = 1.
- char_out  out  DATA_BITS  last correctly framed byte; holds its value between frames.
- char_valid  out  1  one-cycle pulse when char_out is updated.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- busy  out  1  high in every state other than IDLE.
- bit_idx  out  4  current bit index: 0 in IDLE/START, 1–8 in DATA, 9 in STOP/RECOVER.

## Operation
- States: IDLE, START, DATA, STOP, RECOVER.
- Sample counter scnt runs 0..OVERSAMPLE-1. It is held at 0 in IDLE and increments on each enable tick.
- MID = OVERSAMPLE/2-1; LAST = OVERSAMPLE-1.
- IDLE: on a tick with rx_in=0, go to START and set scnt=1. That tick counts as sample 0.
- START: on the tick where scnt==MID:
  - rx_in=0: go to DATA, scnt=0, bit_idx=1.
  - rx_in=1: false start; go to IDLE with no output pulse.
- DATA: on the tick where scnt==LAST:
  - Shift rx_in into the MSB of the shift register (shift right) and set scnt=0.
  - After the DATA_BITS-th bit, go to STOP with bit_idx=9; otherwise bit_idx++.
- STOP: on the tick where scnt==LAST:
  - rx_in=1: char_out <= shift register, pulse char_valid, go to IDLE.
  - rx_in=0: pulse frame_err, leave char_out unchanged, go to RECOVER.
- RECOVER: wait for a tick with rx_in=1, then go to IDLE. A line held low (break) never produces a new start.
- Sampling points land mid-bit, so return to IDLE at the stop sample supports back-to-back frames with no idle gap.
- enable=0 freezes state, scnt, bit_idx and the shift register.
- char_valid and frame_err are never asserted together.

## Timing
- Reset values: state=IDLE, scnt=0, shift register=0, char_out=0, char_valid=0, frame_err=0, busy=0, bit_idx=0.
- Tick numbering: T0 is the detecting tick; with OVERSAMPLE=16 and continuous enable:
  - start check at T7;
  - data bit k (k=0..7) sampled at T(23+16k);
  - stop sampled at T151.
- char_valid / frame_err are registered. Each is high for exactly the one clk cycle after the edge that sampled the stop bit, even if enable is low in that cycle.
- busy rises in the cycle after T0 and falls in the cycle after the stop sample (IDLE path) or after the RECOVER exit.
- rst mid-frame: everything returns to reset values on the next edge and no pulse is emitted. rst has priority over enable.
- Counter widths: scnt is $clog2(OVERSAMPLE) bits. The data-bit counter never wraps because it stops at DATA_BITS.

## Structure
- Package serial_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, RECOVER};
  - localparams FRAME_BITS=10 and STOP_IDX=4'd9 (shared with the bit-index counter and the TX side).
- Sub-module rx_sample_ctr: the scnt counter with enable, clear and mid/last flags. Instantiated once.
- The FSM, shift register and output registers live in serial_rx_frame.

## Test plan
- Continuous enable, frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → char_out=0xA5; char_valid is a single cycle after T151; frame_err=0.
- rx_in low for 4 ticks then high → false start; busy returns to 0 by T7; no pulses; char_out unchanged.
- Frame 0x3C with stop=0, line then held low for 40 ticks → frame_err pulse; char_out keeps its previous value; busy stays 1 until rx_in=1; no second frame detected.
- Back-to-back 0x00 then 0xFF with no idle gap → two char_valid pulses exactly 160 ticks apart; values 0x00 then 0xFF.
- Frame 0x5A with enable asserted one cycle in four → char_out=0x5A; bit_idx progresses 0..9; outputs frozen during enable=0 cycles.
- rst asserted during data bit 4 of 0xC3, then a clean 0x81 frame → no pulse for the aborted frame; all outputs at reset values; next char_out=0x81.
